// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain.

module arith_rsh #(
    parameter int DW  = 16,
    parameter int SHW = 4
) (
    input  logic signed [DW-1:0]  a,
    input  logic        [SHW-1:0] p,
    output logic signed [DW-1:0]  y
);
    assign y = a >>> p;
endmodule

module cordic_rot_iter #(
    parameter int DW   = 16,
    parameter int SHW  = 4,
    parameter int ITER = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    input  logic [DW-1:0] z_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic [DW-1:0] z_out
);

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    localparam int ROWS = 2 ** SHW;

    // Elaboration-time only: angles in radians, quantised to Q2.(DW-3)
    function automatic logic [DW-1:0] atan_q(input int k);
        real v;
        case (k)
            0:       v = 0.7853981633974483;
            1:       v = 0.4636476090008061;
            2:       v = 0.24497866312686414;
            3:       v = 0.12435499454676144;
            4:       v = 0.06241880999595735;
            5:       v = 0.031239833430268277;
            6:       v = 0.015623728620476831;
            7:       v = 0.007812341060101111;
            8:       v = 0.0039062301319669718;
            9:       v = 0.0019531225164788188;
            10:      v = 0.0009765621895593195;
            11:      v = 0.0004882812111948983;
            12:      v = 0.00024414062014936177;
            13:      v = 0.00012207031189367021;
            14:      v = 0.00006103515617420877;
            15:      v = 0.000030517578115526096;
            default: v = 2.0 ** (-k);
        endcase
        return DW'($rtoi(v * (2.0 ** (DW - 3)) + 0.5));
    endfunction

    state_t state, state_n;
    logic [SHW-1:0] i, i_n;
    logic signed [DW-1:0] x, y, z;
    logic signed [DW-1:0] x_n, y_n, z_n;
    logic signed [DW-1:0] xs, ys;
    logic [DW-1:0] xo_n, yo_n, zo_n;
    logic done_n;
    logic [DW-1:0] atan_rom [ROWS];

    genvar g;
    generate
        for (g = 0; g < ROWS; g++) begin : g_rom
            if (g < ITER) begin : g_val
                assign atan_rom[g] = atan_q(g);
            end else begin : g_zero
                assign atan_rom[g] = '0;
            end
        end
    endgenerate

    arith_rsh #(.DW(DW), .SHW(SHW)) u_rsh_x (
        .a (x),
        .p (i),
        .y (xs)
    );

    arith_rsh #(.DW(DW), .SHW(SHW)) u_rsh_y (
        .a (y),
        .p (i),
        .y (ys)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [DW-1:0] KINV =
        DW'($rtoi(0.607253 * (2.0 ** (DW - 1)) + 0.5));
    logic signed [2*DW-1:0] px, py;
    assign px = x * KINV;
    assign py = y * KINV;
`endif

    assign busy = (state == RUN)
`ifdef CORDIC_GAIN_COMP_EN
                | (state == SCALE)
`endif
                ;

    always_comb begin
        state_n = state;
        i_n     = i;
        x_n     = x;
        y_n     = y;
        z_n     = z;
        xo_n    = x_out;
        yo_n    = y_out;
        zo_n    = z_out;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    x_n     = x_in;
                    y_n     = y_in;
                    z_n     = z_in;
                    i_n     = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                // Sign of the residual angle picks the rotation direction
                if (!z[DW-1]) begin
                    x_n = x - ys;
                    y_n = y + xs;
                    z_n = z - atan_rom[i];
                end else begin
                    x_n = x + ys;
                    y_n = y - xs;
                    z_n = z + atan_rom[i];
                end
                i_n = i + SHW'(1);
                if (i == SHW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_n = SCALE;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            SCALE: begin
                x_n     = DW'(px >>> (DW - 1));
                y_n     = DW'(py >>> (DW - 1));
                state_n = DONE;
            end
`endif
            DONE: begin
                xo_n    = x;
                yo_n    = y;
                zo_n    = z;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            i     <= i_n;
            x     <= x_n;
            y     <= y_n;
            z     <= z_n;
            x_out <= xo_n;
            y_out <= yo_n;
            z_out <= zo_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Directed bench for cordic_rot_iter: latency, handshake, reset and rotations.

module tb_cordic_rot_iter;

    localparam int DW = 16;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT   = 18;
    localparam int ID_X  = 4975;
    localparam int P4_XY = 3518;
    localparam int NEG_Y = -8192;
    localparam int TOL   = 6;
`else
    localparam int LAT   = 17;
    localparam int ID_X  = 8192;
    localparam int P4_XY = 5793;
    localparam int NEG_Y = -13490;
    localparam int TOL   = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [DW-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic busy, done;
    logic [DW-1:0] x_out, y_out, z_out;

    int n_cmp = 0;
    int n_bad = 0;

    cordic_rot_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp,
                            input int tol);
        int diff;
        diff = obs - exp;
        n_cmp++;
        assert ((diff <= tol && diff >= -tol) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Issue one start and return edges from start edge to done (-1 on timeout)
    task automatic run_op(input int xv, input int yv, input int zv,
                          output int lat);
        @(posedge clk); #1;
        x_in  = DW'(xv);
        y_in  = DW'(yv);
        z_in  = DW'(zv);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, n_done, first, second, prev_x;

        #2;
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_xout", int'(x_out), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Identity rotation
        run_op(4975, 0, 0, lat);
        chk_eq("id_lat", lat, LAT);
        chk_near("id_x", int'($signed(x_out)), ID_X, 4);
        chk_near("id_y", int'($signed(y_out)), 0, 4);
        chk_near("id_z", int'($signed(z_out)), 0, 2);
        @(posedge clk); #1;
        chk_eq("done_one_cycle", int'(done), 0);
        prev_x = int'($signed(x_out));

        // pi/4 rotation; outputs must hold while the run is busy
        @(posedge clk); #1;
        x_in = 4975; y_in = 0; z_in = 6434; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("busy_mid", int'(busy), 1);
        chk_eq("hold_x", int'($signed(x_out)), prev_x);
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
        end
        chk_eq("p4_done", int'(done), 1);
        chk_near("p4_x", int'($signed(x_out)), P4_XY, 4);
        chk_near("p4_y", int'($signed(y_out)), P4_XY, 4);

        // Negative angle -pi/2
        run_op(8192, 0, -12868, lat);
        chk_eq("neg_lat", lat, LAT);
        chk_near("neg_x", int'($signed(x_out)), 0, TOL);
        chk_near("neg_y", int'($signed(y_out)), NEG_Y, TOL);

        // start held high: exactly two operations in 40 cycles
        @(posedge clk); #1;
        x_in = 4975; y_in = 0; z_in = 0; start = 1'b1;
        n_done = 0; first = -1; second = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        start = 1'b0;
        chk_eq("hs_count", n_done, 2);
        chk_eq("hs_gap", second - first, LAT + 1);
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk_eq("hs_idle", int'(busy), 0);

        // start pulses while busy are ignored
        @(posedge clk); #1;
        x_in = 4975; y_in = 0; z_in = 0; start = 1'b1;
        @(posedge clk); #1;
        x_in = 8192; z_in = 6434;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk_eq("busy_start_ops", n_done, 1);
        chk_near("busy_start_x", int'($signed(x_out)), ID_X, 4);

        // Reset at iteration 7 of a run
        @(posedge clk); #1;
        x_in = 8192; y_in = 0; z_in = 6434; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk_eq("abort_busy_pre", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_done", int'(done), 0);
        chk_eq("abort_x", int'(x_out), 0);
        chk_eq("abort_y", int'(y_out), 0);
        chk_eq("abort_z", int'(z_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk_eq("abort_no_done", n_done, 0);
        run_op(4975, 0, 0, lat);
        chk_eq("post_lat", lat, LAT);
        chk_near("post_x", int'($signed(x_out)), ID_X, 4);
        chk_near("post_y", int'($signed(y_out)), 0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_rot_iter.md
Name: cordic_rot_iter

Overview:
- Iterative rotation-mode CORDIC engine. Rotates vector (x_in, y_in) by angle z_in, one micro-rotation per clock.
- Sits directly upstream of, and drives, the codebase's arithmetic right-shift stage. It owns the iteration counter that supplies the shift amount, and two `arith_rsh` instances (one each for x and y) produce x>>>i and y>>>i.
- Consumes the shifted values to update x/y/z. Outputs the rotated vector scaled by CORDIC gain K≈1.64676 (unless gain compensation is compiled in).

Parameters:
- DW, 16, datapath width. x, y, z are signed two's complement, Q2.(DW-3) fixed point.
- SHW, 4, shift-amount/counter width. Must satisfy 2^SHW ≥ ITER.
- ITER, 16, number of micro-rotations. Legal range 1..DW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- x_in  in  DW  initial x, signed Q2.(DW-3)
- y_in  in  DW  initial y, signed
- z_in  in  DW  rotation angle in radians, signed Q2.(DW-3)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when results are valid
- x_out  out  DW  rotated x
- y_out  out  DW  rotated y
- z_out  out  DW  residual angle

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter i=0.
  - busy=0, done=0, x_out=y_out=z_out=0.
  - Internal x/y/z registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads x←x_in, y←y_in, z←z_in and sets i=0 → RUN.
  - start=0 → stay in IDLE.
  - busy=0.
- RUN (busy=1), one micro-rotation per cycle:
  - d = +1 if z ≥ 0 (sign bit 0), else -1.
  - x ← x − d·(y>>>i)
  - y ← y + d·(x>>>i)
  - z ← z − d·ATAN[i]
  - All three updates use the pre-update values (simultaneous).
  - Shifts come from the `arith_rsh` instances with p=i (sign-preserving).
  - i increments each cycle. When i==ITER−1, the update completes and the state goes → DONE.
- DONE:
  - x_out/y_out/z_out register the final x/y/z.
  - done=1 for exactly this cycle; busy=0.
  - → IDLE unconditionally.
- Latency:
  - start sampled high at edge N → done high in the cycle after edge N+ITER+1.
  - Default: 17 edges after the start edge.
  - Next start accepted the cycle after done.
- Outputs x_out/y_out/z_out hold their values until the next DONE (or reset). Not updated during RUN.
- start while busy or in DONE: ignored, no queueing.
- ATAN[i] = round(atan(2^-i)·2^(DW-3)). Constant table, ITER entries. DW=16 values:
  - [0]=6434 (0x1922)
  - [1]=3798
  - [2]=2007
  - [3]=1019
  - [4]=511
  - entries trend to 1, then 0.
- Arithmetic:
  - Add/sub in DW bits. Overflow wraps (two's complement); no saturation.
  - Caller keeps |x_in|,|y_in| ≤ 2^(DW-1)/(2·K) to avoid wrap.
- Convergence domain: |z_in| ≤ 1.7433 rad (14281 at DW=16). Outside this range the result is undefined but must not hang; the FSM still completes in fixed latency.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done pulse is emitted.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Adds state SCALE between RUN and DONE.
  - x and y are multiplied by K⁻¹≈0.607253 (constant round(0.607253·2^(DW-1)), 19898 at DW=16).
  - Product is truncated back to Q2.(DW-3) by arithmetic shift of DW−1.
  - Latency +1 cycle (default 18). z is unaffected.
- Undefined:
  - No SCALE state, no multiplier.
  - Outputs carry gain K.

Test Plan:
- Reset values: assert rst mid-simulation → busy=0, done=0, x_out=y_out=z_out=0 within the same cycle. Check is asynchronous, no clock edge needed.
- Identity rotation, macro off: x_in=4975 (≈K⁻¹·1.0), y_in=0, z_in=0 → done after 17 edges. Expect x_out=8192±4, y_out=0±4, |z_out|≤2.
- π/4 rotation, macro off: x_in=4975, y_in=0, z_in=6434 → x_out≈y_out≈5793±4.
- Negative angle −π/2, macro on: x_in=8192, y_in=0, z_in=−12868 → x_out=0±6, y_out=−8192±6. Latency 18 edges.
- Handshake: start held high continuously for 40 cycles → exactly two done pulses, 18 cycles apart (17 latency + 1 IDLE). start pulses while busy cause no extra operations.
- Reset mid-operation: assert rst at iteration 7 of a run, release, then start a new run with x_in=4975, y_in=0, z_in=0 → no done from the aborted run. New run result matches the identity test.
